// File: rtl/com_uart_tx_sched_pkg.sv
// Shared UART TX scheduler types: frame config encodings,
// TX engine state codes and the shadow config bundle.
package com_uart_tx_sched_pkg;

  localparam int PAR_EN  = 1;
  localparam int PAR_ODD = 0;

  typedef enum logic [1:0] {
    DATA_5 = 2'd0,
    DATA_6 = 2'd1,
    DATA_7 = 2'd2,
    DATA_8 = 2'd3
  } data_bits_e;

  typedef enum logic {
    STOP_1 = 1'b0,
    STOP_2 = 1'b1
  } stop_bits_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_STOP   = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic       stop;
    logic [1:0] parity;
    logic [1:0] data;
  } frame_cfg_t;

endpackage

// File: rtl/com_uart_tx_fifo.sv
// Byte FIFO between the requester arbiter and the TX engine.
// Power-of-two depth; pointers wrap naturally.
module com_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/com_uart_tx_sched.sv
// UART TX scheduler: round-robin of two byte requesters into a
// FIFO, gated baud generation and per-frame config shadowing.
module com_uart_tx_sched
  import com_uart_tx_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req0_data,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req1_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             cfg_stop_bit,
  input  logic [1:0]       cfg_parity,
  input  logic [1:0]       cfg_data_bit,
  input  logic             ctrl_idle_state,
  input  logic             ctrl_stop_state,
  output logic [7:0]       tx_data_bus,
  output logic             tx_timer_baudrate,
  output logic             tx_stop_bit_config,
  output logic [1:0]       tx_parity_bit_config,
  output logic [1:0]       tx_data_bit_config,
  output logic             tx_busy,
  output logic             fifo_full,
  output logic             fifo_empty
);

  logic             live_q;
  logic             last_q;
  logic             idle_q;
  logic             baud_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_eff;
  frame_cfg_t       cfg_q;

  logic       grant0;
  logic       grant1;
  logic       push0;
  logic       push1;
  logic [7:0] push_data;
  logic       en;
  logic       wrap;
  logic       tick;
  logic       pop;

  // A requester holds the grant unless the other one wins it.
  assign grant0 = !(req1_valid && (!req0_valid || !last_q));
  assign grant1 = !(req0_valid && (!req1_valid || last_q));

  assign req0_ready = live_q && grant0 && !fifo_full;
  assign req1_ready = live_q && grant1 && !fifo_full;
  assign push0      = req0_valid && req0_ready;
  assign push1      = req1_valid && req1_ready;
  assign push_data  = push1 ? req1_data : req0_data;

  assign en      = !idle_q || !fifo_empty;
  assign div_eff = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign wrap    = (cnt_q == div_q - 1'b1);
  assign tick    = en && (cnt_q == '0) && idle_q && !fifo_empty;
  // Engine left IDLE since last clk: it has taken the head byte.
  assign pop     = idle_q && !ctrl_idle_state && !ctrl_stop_state;

  com_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push0 || push1),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (tx_data_bus),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
      last_q <= 1'b1;
      idle_q <= 1'b1;
      baud_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= DIV_W'(2);
      cfg_q  <= '0;
    end else begin
      live_q <= 1'b1;
      idle_q <= ctrl_idle_state;
      if (push0 || push1) last_q <= push1;
      // Divider is only reloaded between baud periods.
      if (!en || wrap) div_q <= div_eff;
      if (!en || wrap) cnt_q <= '0;
      else             cnt_q <= cnt_q + 1'b1;
      baud_q <= en && (cnt_q < (div_q >> 1));
      if (tick) begin
        cfg_q.stop   <= cfg_stop_bit;
        cfg_q.parity <= cfg_parity;
        cfg_q.data   <= cfg_data_bit;
      end
    end
  end

  assign tx_timer_baudrate    = baud_q;
  assign tx_stop_bit_config   = cfg_q.stop;
  assign tx_parity_bit_config = cfg_q.parity;
  assign tx_data_bit_config   = cfg_q.data;
  assign tx_busy              = en;

endmodule

// File: tb/tb_com_uart_tx_sched.sv
// Directed bench for com_uart_tx_sched with a behavioural
// TX engine clocked by the gated baud output.
module tb_com_uart_tx_sched;
  import com_uart_tx_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req0_data, req1_data;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] baud_div;
  logic        cfg_stop_bit;
  logic [1:0]  cfg_parity, cfg_data_bit;
  logic        ctrl_idle_state, ctrl_stop_state;
  logic [7:0]  tx_data_bus;
  logic        tx_timer_baudrate, tx_stop_bit_config;
  logic [1:0]  tx_parity_bit_config, tx_data_bit_config;
  logic        tx_busy, fifo_full, fifo_empty;

  int n_chk  = 0;
  int n_fail = 0;
  bit saw_full;

  tx_state_e  st = TX_IDLE;
  logic [7:0] sh, mask;
  int         nb, bi, sc;
  logic       podd, pen, s2, line, pbit;
  logic [7:0] rxq[$];
  logic       parq[$];
  logic       lineq[$];
  longint     tq[$];

  com_uart_tx_sched #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .baud_div(baud_div), .cfg_stop_bit(cfg_stop_bit),
    .cfg_parity(cfg_parity), .cfg_data_bit(cfg_data_bit),
    .ctrl_idle_state(ctrl_idle_state),
    .ctrl_stop_state(ctrl_stop_state),
    .tx_data_bus(tx_data_bus),
    .tx_timer_baudrate(tx_timer_baudrate),
    .tx_stop_bit_config(tx_stop_bit_config),
    .tx_parity_bit_config(tx_parity_bit_config),
    .tx_data_bit_config(tx_data_bit_config),
    .tx_busy(tx_busy), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  assign ctrl_idle_state = (st == TX_IDLE);
  assign ctrl_stop_state = (st == TX_STOP);

  // Engine: one step per rising edge of the gated baud clock.
  initial begin
    line = 1'b1;
    forever begin
      @(posedge tx_timer_baudrate or negedge rst_n);
      if (!rst_n) begin
        st = TX_IDLE;
        line = 1'b1;
      end else begin
        tq.push_back($time);
        case (st)
          TX_IDLE: begin
            sh = tx_data_bus; line = 1'b0; st = TX_START;
          end
          TX_START: begin
            nb = int'(tx_data_bit_config) + 5;
            mask = 8'(8'hFF >> (8 - nb));
            pen = tx_parity_bit_config[1];
            podd = tx_parity_bit_config[0];
            s2 = tx_stop_bit_config;
            line = sh[0]; bi = 1; st = TX_DATA;
          end
          TX_DATA: begin
            if (bi < nb) begin
              line = sh[bi]; bi++;
            end else if (pen) begin
              pbit = (^(sh & mask)) ^ podd;
              parq.push_back(pbit);
              line = pbit; st = TX_PARITY;
            end else begin
              line = 1'b1; sc = 0; st = TX_STOP;
            end
          end
          TX_PARITY: begin
            line = 1'b1; sc = 0; st = TX_STOP;
          end
          default: begin
            if (s2 && sc == 0) begin
              sc = 1; line = 1'b1;
            end else begin
              line = 1'b1; st = TX_IDLE;
              rxq.push_back(sh & mask);
            end
          end
        endcase
        lineq.push_back(line);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rxq.delete(); parq.delete(); lineq.delete(); tq.delete();
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clr();
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    bit ok = 0;
    if (ch == 0) begin req0_data = d; req0_valid = 1'b1; end
    else begin req1_data = d; req1_valid = 1'b1; end
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if ((ch == 0) ? req0_ready : req1_ready) begin
        ok = 1; break;
      end
      if (fifo_full) saw_full = 1;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_rx(input string tag, input int n);
    bit ok = 0;
    for (int k = 0; k < 8000; k++) begin
      @(posedge clk); #1;
      if (rxq.size() >= n && !tx_busy) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (tq.size() >= n) break;
    end
  endtask

  initial begin
    logic [7:0] acc[$];
    logic [10:0] pat;
    bit ok;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_data = 0; req1_data = 0;
    baud_div = 16'd4;
    cfg_stop_bit = 1'b0; cfg_parity = 2'b00;
    cfg_data_bit = DATA_8;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_baud", tx_timer_baudrate, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_shadow", {tx_stop_bit_config, tx_parity_bit_config,
                       tx_data_bit_config}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 1);

    // 1: single 8N1 byte, baud_div 4
    clr();
    push(0, 8'hA5);
    wait_rx("t1_done", 1);
    repeat (10) @(posedge clk); #1;
    chk("t1_ticks", tq.size(), 11);
    ok = 1;
    for (int i = 1; i < tq.size(); i++)
      if (tq[i] - tq[i-1] != 40) ok = 0;
    chk("t1_period", ok, 1);
    pat = '0;
    for (int i = 0; i < 11 && i < lineq.size(); i++)
      pat[10-i] = lineq[i];
    chk("t1_line", pat, 11'b0_1010_0101_11);
    chk("t1_rx", rxq[0], 8'hA5);
    chk("t1_shadow_db", tx_data_bit_config, DATA_8);
    chk("t1_baud_low", tx_timer_baudrate, 0);
    chk("t1_busy", tx_busy, 0);

    // 2: both requesters continuously valid
    do_reset();
    req0_data = 8'h11; req1_data = 8'h22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 200 && acc.size() < 4; k++) begin
      @(negedge clk);
      if (req0_ready) acc.push_back(8'h11);
      if (req1_ready) acc.push_back(8'h22);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t2_acc_n", acc.size(), 4);
    chk("t2_acc", {acc[0], acc[1], acc[2], acc[3]}, 32'h11221122);
    wait_rx("t2_done", 4);
    chk("t2_rx", {rxq[0], rxq[1], rxq[2], rxq[3]}, 32'h11221122);

    // 3: slow baud, 8 back-to-back bytes
    do_reset();
    baud_div = 16'd40;
    saw_full = 0;
    for (int i = 0; i < 8; i++) push(0, 8'(8'h30 + i));
    chk("t3_saw_full", saw_full, 1);
    wait_rx("t3_done", 8);
    chk("t3_rx_n", rxq.size(), 8);
    ok = 1;
    for (int i = 0; i < 8 && i < rxq.size(); i++)
      if (rxq[i] != 8'(8'h30 + i)) ok = 0;
    chk("t3_order", ok, 1);

    // 4: parity config changed mid-frame
    do_reset();
    baud_div = 16'd4;
    cfg_parity = 2'b10;
    push(0, 8'h3C);
    push(0, 8'h3C);
    wait_ticks(3);
    cfg_parity = 2'b11;
    @(posedge clk); #1;
    chk("t4_frozen", tx_parity_bit_config, 2'b10);
    wait_rx("t4_done", 2);
    chk("t4_par_n", parq.size(), 2);
    chk("t4_par", {parq[0], parq[1]}, 2'b01);
    chk("t4_shadow", tx_parity_bit_config, 2'b11);
    cfg_parity = 2'b00;

    // 5: reset during a data bit
    do_reset();
    push(0, 8'h5A);
    push(0, 8'h66);
    wait_ticks(3);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("t5_baud", tx_timer_baudrate, 0);
    chk("t5_empty", fifo_empty, 1);
    chk("t5_rdy", {req0_ready, req1_ready}, 2'b00);
    chk("t5_busy", tx_busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_rdy_after", {req0_ready, req1_ready}, 2'b11);
    clr();
    push(1, 8'hC3);
    wait_rx("t5_done", 1);
    chk("t5_rx_n", rxq.size(), 1);
    chk("t5_rx", rxq[0], 8'hC3);

    // 6: divider 0 and 1 act as 2
    for (int d = 0; d < 2; d++) begin
      do_reset();
      baud_div = 16'(d);
      push(0, 8'h81);
      for (int k = 0; k < 50; k++) begin
        @(posedge clk); #1;
        if (tx_timer_baudrate) break;
      end
      @(posedge clk); #1;
      chk("t6_low", tx_timer_baudrate, 0);
      @(posedge clk); #1;
      chk("t6_high", tx_timer_baudrate, 1);
      wait_rx("t6_done", 1);
      chk("t6_rx", rxq[0], 8'h81);
      chk("t6_gap", 32'(tq[1] - tq[0]), 20);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
